// File: rtl/audio_line_prefetch.sv
// Audio line prefetcher: pulls 128-bit lines from the SDRAM arbiter into a small
// ring buffer and hands out one 16-bit PCM sample per I2S request.
module audio_line_prefetch #(
   parameter logic [21:0] BASE_ADDR   = 22'h000000,
   parameter logic [21:0] NUM_LINES   = 22'h040000,
   parameter int unsigned DEPTH_LINES = 4
) (
   input  logic         i_clk,
   input  logic         i_reset_n,
   input  logic         i_start,
   input  logic         i_stop,
   output logic         o_sdram_rd,
   output logic [21:0]  o_sdram_addr,
   input  logic         i_sdram_wait,
   input  logic         i_sdram_ac,
   input  logic [127:0] i_sdram_rddata,
   input  logic         i_sample_req,
   output logic [15:0]  o_sample_data,
   output logic         o_sample_valid,
   output logic         o_underrun,
   output logic         o_busy,
   output logic         o_done,
   output logic [3:0]   o_level
);

   localparam int unsigned PW = (DEPTH_LINES > 1) ? $clog2(DEPTH_LINES) : 1;
   localparam int unsigned LW = PW + 1;
   localparam logic [LW-1:0] FULL = LW'(DEPTH_LINES);
   localparam logic [22:0]   LAST = {1'b0, NUM_LINES};

   typedef enum logic [2:0] {StIdle, StFill, StRun, StDone, StAbort} state_t;

   state_t          r_state;
   logic            r_rd;
   logic [21:0]     r_addr;
   logic [22:0]     r_fetch_cnt;
   logic [PW-1:0]   r_wptr;
   logic [PW-1:0]   r_rptr;
   logic [LW-1:0]   r_level;
   logic [2:0]      r_k;
   logic [15:0]     r_sample_data;
   logic            r_sample_valid;
   logic            r_underrun;
   logic            r_busy;
   logic            r_done;
   logic [127:0]    r_mem [DEPTH_LINES];

   state_t          w_state_d;
   logic            w_rd_done;
   logic            w_active;
   logic            w_start_acc;
   logic            w_write;
   logic            w_serve;
   logic            w_empty_req;
   logic            w_free;
   logic            w_room;
   logic            w_more;
   logic            w_issue;
   logic            w_clear;
   logic [127:0]    w_line;
   logic [15:0]     w_cur_sample;
   logic            w_unused;

   // The request is held until ack no matter what the arbiter says, so wait is
   // informational only.
   assign w_unused = i_sdram_wait;

   // Event decode for the current cycle.
   always_comb begin
      w_rd_done    = r_rd & i_sdram_ac;
      w_active     = (r_state == StFill) | (r_state == StRun);
      w_start_acc  = i_start & ((r_state == StIdle) | (r_state == StDone));
      w_write      = w_active & ~i_stop & w_rd_done;
      w_serve      = (r_state == StRun) & i_sample_req & ~i_stop & (r_level != '0);
      // Any request not served (FILL, empty buffer, IDLE/DONE/ABORT) counts as empty,
      // except when stop arrives in the same cycle.
      w_empty_req  = i_sample_req & ~i_stop & ~w_serve;
      w_free       = w_serve & (r_k == 3'd7);
      w_room       = r_level < FULL;
      w_more       = r_fetch_cnt < LAST;
      w_issue      = w_start_acc | (w_active & ~i_stop & ~r_rd & w_room & w_more);
      w_line       = r_mem[r_rptr];
      w_cur_sample = w_line[{r_k, 4'b0000} +: 16];
   end

   // Next-state selection.
   always_comb begin
      w_state_d = r_state;
      w_clear   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_d = StFill;
               w_clear   = 1'b1;
            end
         end
         StFill: begin
            if (i_stop) begin
               w_state_d = StAbort;
            end else if ((r_level == FULL) || !w_more) begin
               w_state_d = StRun;
            end
         end
         StRun: begin
            if (i_stop) begin
               w_state_d = StAbort;
            end else if (!w_more && (r_level == '0) && !r_rd) begin
               w_state_d = StDone;
            end
         end
         StDone: begin
            if (i_start) begin
               w_state_d = StFill;
               w_clear   = 1'b1;
            end else if (i_stop) begin
               w_state_d = StIdle;
               w_clear   = 1'b1;
            end
         end
         StAbort: begin
            // Wait out an outstanding read; its data is dropped.
            if (!r_rd || i_sdram_ac) begin
               w_state_d = StIdle;
               w_clear   = 1'b1;
            end
         end
         default: w_state_d = StIdle;
      endcase
   end

   // State, read handshake, buffer bookkeeping and registered outputs.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state        <= StIdle;
         r_rd           <= 1'b0;
         r_addr         <= '0;
         r_fetch_cnt    <= '0;
         r_wptr         <= '0;
         r_rptr         <= '0;
         r_level        <= '0;
         r_k            <= '0;
         r_sample_data  <= '0;
         r_sample_valid <= 1'b0;
         r_underrun     <= 1'b0;
         r_busy         <= 1'b0;
         r_done         <= 1'b0;
      end else begin
         r_state <= w_state_d;
         r_busy  <= (w_state_d == StFill) || (w_state_d == StRun) || (w_state_d == StAbort);
         r_done  <= (w_state_d == StDone);

         if (w_issue) begin
            r_rd   <= 1'b1;
            r_addr <= w_start_acc ? BASE_ADDR : BASE_ADDR + r_fetch_cnt[21:0];
         end else if (w_rd_done) begin
            r_rd <= 1'b0;
         end

         if (w_clear) begin
            r_fetch_cnt <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_level     <= '0;
            r_k         <= '0;
         end else begin
            if (w_write) begin
               r_wptr      <= r_wptr + 1'b1;
               r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
            if (w_serve) begin
               r_k <= r_k + 1'b1;
            end
            if (w_free) begin
               r_rptr <= r_rptr + 1'b1;
            end
            r_level <= r_level + LW'(w_write) - LW'(w_free);
         end

         if (w_serve) begin
            r_sample_data  <= w_cur_sample;
            r_sample_valid <= 1'b1;
         end else begin
            r_sample_valid <= 1'b0;
            if (i_sample_req) begin
               r_sample_data <= '0;
            end
         end

         if (w_start_acc) begin
            r_underrun <= 1'b0;
         end else if (w_empty_req) begin
            r_underrun <= 1'b1;
         end
      end
   end

   // Line storage; contents are don't-care after reset.
   always_ff @(posedge i_clk) begin
      if (w_write) begin
         r_mem[r_wptr] <= i_sdram_rddata;
      end
   end

   assign o_sdram_rd     = r_rd;
   assign o_sdram_addr   = r_addr;
   assign o_sample_data  = r_sample_data;
   assign o_sample_valid = r_sample_valid;
   assign o_underrun     = r_underrun;
   assign o_busy         = r_busy;
   assign o_done         = r_done;
   assign o_level        = 4'(r_level);

endmodule

// File: doc/audio_line_prefetch.md
Name: audio_line_prefetch

Overview:
- Sits between the SDRAM arbiter and the I2S serializer. Prefetches 128-bit audio lines from SDRAM through the arbiter's read handshake and buffers up to DEPTH_LINES of them.
- Serves one 16-bit PCM sample per request from the I2S stage, so audio keeps playing while video and lane drawers hold the arbiter.
- Tracks song length, reports underrun and end-of-song.

Parameters:
- BASE_ADDR, 22'h000000, line address of the first audio line (units of 128-bit words).
- NUM_LINES, 22'h040000, number of lines in the song; must be >= 1.
- DEPTH_LINES, 4, line buffer depth; power of two, 2..8.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins playback from BASE_ADDR.
- stop  in  1  one-cycle pulse; aborts playback.
- sdram_rd  out  1  read request to the arbiter.
- sdram_addr  out  22  line address of the request.
- sdram_wait  in  1  arbiter serving another client; request must be held.
- sdram_ac  in  1  acknowledge; sdram_rddata is valid in this cycle.
- sdram_rddata  in  128  returned line.
- sample_req  in  1  one-cycle pulse from I2S per channel slot (L and R alternate).
- sample_data  out  16  current sample; held between requests.
- sample_valid  out  1  one-cycle pulse when sample_data updates from the buffer.
- underrun  out  1  sticky; a request found the buffer empty.
- busy  out  1  high in FILL, RUN and ABORT.
- done  out  1  high in DONE.
- level  out  4  number of lines currently buffered.

Behaviour:
- Reset (asynchronous on reset_n low): all outputs 0; state IDLE; pointers and counters 0; buffer contents don't-care.
- Line format: sample k (k = 0..7) = sdram_rddata[16k+15:16k]; k = 0 is emitted first. Even k is L, odd k is R.
- States:
  - IDLE: start -> FILL. stop is ignored.
  - FILL: fetch until level == DEPTH_LINES or all lines have been fetched -> RUN. sample_req in FILL is treated as an empty-buffer request.
  - RUN: refill whenever level < DEPTH_LINES and fetch_cnt < NUM_LINES. When fetch_cnt == NUM_LINES, level == 0 and no read is outstanding -> DONE.
  - DONE: start -> FILL (restart); stop -> IDLE.
  - ABORT: entered on stop in FILL or RUN.
    - If a read is outstanding, keep sdram_rd high until sdram_ac, then discard the data.
    - Then -> IDLE with level, pointers and counters cleared.
    - start in ABORT is ignored.
- start during FILL or RUN is ignored.
- Read handshake:
  - sdram_rd rises the cycle after the issue decision, e.g. the first cycle after start.
  - sdram_addr is stable while sdram_rd is high.
  - sdram_rd stays high regardless of sdram_wait until sdram_ac is sampled.
  - The line is written to the buffer in the sdram_ac cycle. sdram_rd drops the next cycle; fetch_cnt increments.
  - Only one read is outstanding. The next request may assert no earlier than 1 cycle after the ac cycle.
  - sdram_ac while sdram_rd is low is ignored.
- Address: sdram_addr = BASE_ADDR + fetch_cnt, modulo 2^22 (wraps silently).
- Sample path:
  - sample_req with level > 0: sample_data = current line[k] and sample_valid = 1, both in the next cycle. Then k increments.
  - After k = 7 is emitted, the line is freed: level decrements, the read pointer advances and k returns to 0.
  - sample_req with level == 0: sample_data = 0 the next cycle, sample_valid stays 0, underrun set.
  - underrun clears only on start or reset.
- Simultaneous events:
  - sdram_ac and a line-freeing sample_req in the same cycle: level is unchanged net, and the write and read pointers both advance.
  - A write into a full buffer cannot occur, because no request is issued at level == DEPTH_LINES.
  - stop and sample_req in the same cycle: stop wins; sample_data is forced to 0 and sample_valid stays 0.
- Pointers wrap modulo DEPTH_LINES. level ranges 0..DEPTH_LINES.
- busy is high in FILL, RUN and ABORT. done is high only in DONE.

Test Plan:
- Basic fill: BASE_ADDR = 22'h000100, NUM_LINES = 16, start, arbiter acks 3 cycles after each rd -> reads at 0x100, 0x101, 0x102, 0x103; level = 4; state RUN; sdram_rd low.
- Sample order: line 0 = 128'h0007_0006_0005_0004_0003_0002_0001_0000, issue 9 sample_req -> sample_data sequence 0,1,...,7, then the first sample of line 1; level decrements after the 8th; a refill rd for 0x104 follows.
- Arbiter stall: hold sdram_wait = 1 for 200 cycles with sdram_ac = 0 -> sdram_rd and sdram_addr stay constant; no buffer write.
- Underrun: NUM_LINES = 1, consume all 8 samples, request a 9th -> sample_data = 0, sample_valid = 0, underrun = 1; DONE entered, done = 1; underrun still 1 until the next start.
- Stop mid-read: stop while sdram_rd is high, ack 5 cycles later -> rd held until ack, data discarded, IDLE, level = 0, busy = 0.
- Reset mid-operation: drop reset_n asynchronously in RUN with level = 3 -> all outputs 0 immediately; after release, start fetches from BASE_ADDR again.
